// File: rtl/wash_cycle_controller_if.sv
// Front-panel/sensor to controller bundle: the panel side drives requests and
// sensor levels, the controller drives state, actuator enables and status.
interface wash_cycle_controller_if #(
    parameter int CNT_W   = 16,
    parameter int RINSE_W = 2
);
    logic               start;
    logic               pause;
    logic               door_closed;
    logic               water_full;
    logic               detergent_done;
    logic               drained;
    logic [RINSE_W-1:0] rinse_count;
    logic [CNT_W-1:0]   wash_time;
    logic [CNT_W-1:0]   spin_time;

    logic [3:0]         state;
    logic               door_lock;
    logic               fill_valve;
    logic               detergent_valve;
    logic               motor_wash;
    logic               drain_pump;
    logic               motor_spin;
    logic [RINSE_W-1:0] rinse_left;
    logic               done;
    logic [1:0]         error_code;

    modport master (
        output start, pause, door_closed, water_full, detergent_done, drained,
               rinse_count, wash_time, spin_time,
        input  state, door_lock, fill_valve, detergent_valve, motor_wash,
               drain_pump, motor_spin, rinse_left, done, error_code
    );

    modport slave (
        input  start, pause, door_closed, water_full, detergent_done, drained,
               rinse_count, wash_time, spin_time,
        output state, door_lock, fill_valve, detergent_valve, motor_wash,
               drain_pump, motor_spin, rinse_left, done, error_code
    );
endinterface

// File: rtl/wash_cycle_controller.sv
// Washing machine sequencer: fill, detergent, timed wash, N rinses, drain, timed
// spin, with pause/resume, fill/drain watchdogs and door-open fault detection.
module wash_cycle_controller #(
    parameter int CNT_W         = 16,
    parameter int RINSE_W       = 2,
    parameter int FILL_TIMEOUT  = 200,
    parameter int DRAIN_TIMEOUT = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    wash_cycle_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CHECK_DOOR = 4'd1,
        S_FILL       = 4'd2,
        S_DETERGENT  = 4'd3,
        S_WASH       = 4'd4,
        S_DRAIN      = 4'd5,
        S_RINSE_FILL = 4'd6,
        S_RINSE      = 4'd7,
        S_SPIN       = 4'd8,
        S_DONE       = 4'd9,
        S_PAUSED     = 4'd10,
        S_ERROR      = 4'd11
    } state_t;

    localparam logic [CNT_W:0]     CNT_ONE   = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]     FILL_LIM  = (CNT_W+1)'(FILL_TIMEOUT);
    localparam logic [CNT_W:0]     DRAIN_LIM = (CNT_W+1)'(DRAIN_TIMEOUT);
    localparam logic [RINSE_W-1:0] RINSE_ONE = RINSE_W'(1);

    state_t             state_reg, state_next;
    state_t             ret_state_reg, ret_state_next;
    logic [CNT_W-1:0]   timer_reg, timer_next;
    logic [CNT_W-1:0]   wash_time_reg, wash_time_next;
    logic [CNT_W-1:0]   spin_time_reg, spin_time_next;
    logic [RINSE_W-1:0] rinse_left_reg, rinse_left_next;
    logic [1:0]         error_code_reg, error_code_next;

    logic [CNT_W-1:0]   limit;
    logic [CNT_W:0]     timer_inc;
    logic               timer_hit;
    logic               is_run;
    logic               is_counting;

    assign is_run      = (state_reg >= S_FILL) && (state_reg <= S_SPIN);
    assign is_counting = is_run && (state_reg != S_DETERGENT);
    assign timer_inc   = {1'b0, timer_reg} + CNT_ONE;
    // A zero limit compares as already reached, so timed states last at least one cycle.
    assign timer_hit   = timer_inc >= {1'b0, limit};

    always_comb begin
        limit = '0;
        case (state_reg)
            S_WASH:  limit = wash_time_reg;
            S_RINSE: limit = wash_time_reg >> 1;
            S_SPIN:  limit = spin_time_reg;
            default: limit = '0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        ret_state_next  = ret_state_reg;
        wash_time_next  = wash_time_reg;
        spin_time_next  = spin_time_reg;
        rinse_left_next = rinse_left_reg;
        error_code_next = error_code_reg;
        timer_next      = '0;

        if ((is_run || state_reg == S_PAUSED) && !bus.door_closed) begin
            state_next      = S_ERROR;
            error_code_next = 2'd3;
        end else if (is_run && bus.pause) begin
            state_next     = S_PAUSED;
            ret_state_next = state_reg;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        rinse_left_next = bus.rinse_count;
                        wash_time_next  = bus.wash_time;
                        spin_time_next  = bus.spin_time;
                        state_next      = S_CHECK_DOOR;
                    end
                end
                S_CHECK_DOOR: if (bus.door_closed) state_next = S_FILL;
                S_FILL, S_RINSE_FILL: begin
                    if (bus.water_full) begin
                        state_next = (state_reg == S_FILL) ? S_DETERGENT : S_RINSE;
                    end else if (timer_inc >= FILL_LIM) begin
                        state_next      = S_ERROR;
                        error_code_next = 2'd1;
                    end
                end
                S_DETERGENT: if (bus.detergent_done) state_next = S_WASH;
                S_WASH:      if (timer_hit) state_next = S_DRAIN;
                S_DRAIN: begin
                    if (bus.drained) begin
                        if (rinse_left_reg != '0) begin
                            rinse_left_next = rinse_left_reg - RINSE_ONE;
                            state_next      = S_RINSE_FILL;
                        end else begin
                            state_next = S_SPIN;
                        end
                    end else if (timer_inc >= DRAIN_LIM) begin
                        state_next      = S_ERROR;
                        error_code_next = 2'd2;
                    end
                end
                S_RINSE:  if (timer_hit) state_next = S_DRAIN;
                S_SPIN:   if (timer_hit) state_next = S_DONE;
                S_DONE:   state_next = S_IDLE;
                S_PAUSED: if (!bus.pause) state_next = ret_state_reg;
                S_ERROR:  state_next = S_ERROR;
                default:  state_next = S_IDLE;
            endcase
        end

        // The cycle spent before a pause counts; time in PAUSED does not.
        if (state_next == S_PAUSED && state_reg != S_PAUSED) begin
            timer_next = timer_inc[CNT_W-1:0];
        end else if (state_reg == S_PAUSED && state_next != S_ERROR) begin
            timer_next = timer_reg;
        end else if (state_next != state_reg) begin
            timer_next = '0;
        end else if (is_counting) begin
            timer_next = timer_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            ret_state_reg  <= S_IDLE;
            timer_reg      <= '0;
            wash_time_reg  <= '0;
            spin_time_reg  <= '0;
            rinse_left_reg <= '0;
            error_code_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ret_state_reg  <= ret_state_next;
            timer_reg      <= timer_next;
            wash_time_reg  <= wash_time_next;
            spin_time_reg  <= spin_time_next;
            rinse_left_reg <= rinse_left_next;
            error_code_reg <= error_code_next;
        end
    end

    assign bus.state           = state_reg;
    assign bus.door_lock       = is_run || (state_reg == S_PAUSED);
    assign bus.fill_valve      = (state_reg == S_FILL) || (state_reg == S_RINSE_FILL);
    assign bus.detergent_valve = (state_reg == S_DETERGENT);
    assign bus.motor_wash      = (state_reg == S_WASH) || (state_reg == S_RINSE);
    assign bus.drain_pump      = (state_reg == S_DRAIN) || (state_reg == S_SPIN);
    assign bus.motor_spin      = (state_reg == S_SPIN);
    assign bus.done            = (state_reg == S_DONE);
    assign bus.rinse_left      = rinse_left_reg;
    assign bus.error_code      = error_code_reg;
endmodule

// File: tb/tb_wash_cycle_controller.sv
// Scoreboard bench: each phase pushes the expected per-cycle output word when it
// drives stimulus, then pops and compares one word per clock on the falling edge.
module tb_wash_cycle_controller;
    localparam int CNT_W   = 16;
    localparam int RINSE_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wash_cycle_controller_if #(.CNT_W(CNT_W), .RINSE_W(RINSE_W)) bus ();

    wash_cycle_controller #(
        .CNT_W(CNT_W), .RINSE_W(RINSE_W), .FILL_TIMEOUT(200), .DRAIN_TIMEOUT(200)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    err_cnt = 0;
    int    chk_cnt = 0;
    string phase   = "reset";
    logic [14:0] exp_q[$];
    logic [14:0] dut_word;

    assign dut_word = {bus.state, bus.door_lock, bus.fill_valve, bus.detergent_valve,
                       bus.motor_wash, bus.drain_pump, bus.motor_spin, bus.done,
                       bus.rinse_left, bus.error_code};

    // Expected outputs for a given state straight from the actuator table.
    function automatic logic [14:0] exp_word(input logic [3:0] st, input logic [1:0] rl,
                                             input logic [1:0] ec);
        logic lock, fill, det, mw, dp, ms, dn;
        lock = (st >= 4'd2 && st <= 4'd8) || st == 4'd10;
        fill = (st == 4'd2) || (st == 4'd6);
        det  = (st == 4'd3);
        mw   = (st == 4'd4) || (st == 4'd7);
        dp   = (st == 4'd5) || (st == 4'd8);
        ms   = (st == 4'd8);
        dn   = (st == 4'd9);
        return {st, lock, fill, det, mw, dp, ms, dn, rl, ec};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input int n, input logic [1:0] rl,
                        input logic [1:0] ec);
        repeat (n) exp_q.push_back(exp_word(st, rl, ec));
    endtask

    task automatic consume();
        logic [14:0] e;
        int n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_value($sformatf("%s_c%0d", phase, n), {17'd0, dut_word}, {17'd0, e});
            n++;
        end
        $display("tx %s: %0d cycles compared, state now %0d", phase, n, bus.state);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        push(4'd0, 1, 2'd0, 2'd0);
        consume();
        reset = 1'b0;
        push(4'd0, 1, 2'd0, 2'd0);
        consume();
    endtask

    task automatic start_run(input logic [1:0] rc, input logic [15:0] wt, input logic [15:0] sp);
        bus.rinse_count = rc;
        bus.wash_time   = wt;
        bus.spin_time   = sp;
        bus.start       = 1'b1;
        push(4'd1, 1, rc, 2'd0);
        consume();
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.pause          = 1'b0;
        bus.door_closed    = 1'b1;
        bus.water_full     = 1'b1;
        bus.detergent_done = 1'b1;
        bus.drained        = 1'b1;
        bus.rinse_count    = '0;
        bus.wash_time      = '0;
        bus.spin_time      = '0;

        push(4'd0, 2, 2'd0, 2'd0);
        consume();
        reset = 1'b0;
        push(4'd0, 2, 2'd0, 2'd0);
        consume();

        // Nominal run; inputs changed after start must be ignored.
        phase = "nominal";
        start_run(2'd2, 16'd10, 16'd8);
        bus.rinse_count = 2'd0;
        bus.wash_time   = 16'd3;
        bus.spin_time   = 16'd1;
        push(4'd2, 1, 2'd2, 2'd0); push(4'd3, 1, 2'd2, 2'd0);
        push(4'd4, 10, 2'd2, 2'd0); push(4'd5, 1, 2'd2, 2'd0);
        push(4'd6, 1, 2'd1, 2'd0); push(4'd7, 5, 2'd1, 2'd0); push(4'd5, 1, 2'd1, 2'd0);
        push(4'd6, 1, 2'd0, 2'd0); push(4'd7, 5, 2'd0, 2'd0); push(4'd5, 1, 2'd0, 2'd0);
        push(4'd8, 8, 2'd0, 2'd0); push(4'd9, 1, 2'd0, 2'd0); push(4'd0, 3, 2'd0, 2'd0);
        consume();

        // Fill watchdog, then start is ignored in ERROR.
        phase = "fill_timeout";
        bus.water_full = 1'b0;
        start_run(2'd0, 16'd4, 16'd4);
        push(4'd2, 200, 2'd0, 2'd0); push(4'd11, 3, 2'd0, 2'd1);
        consume();
        bus.start = 1'b1;
        push(4'd11, 4, 2'd0, 2'd1);
        consume();
        bus.start = 1'b0;
        bus.water_full = 1'b1;
        apply_reset();

        // Pause after the fourth WASH cycle for 20 cycles.
        phase = "pause";
        start_run(2'd0, 16'd10, 16'd2);
        push(4'd2, 1, 2'd0, 2'd0); push(4'd3, 1, 2'd0, 2'd0); push(4'd4, 4, 2'd0, 2'd0);
        consume();
        bus.pause = 1'b1;
        push(4'd10, 20, 2'd0, 2'd0);
        consume();
        bus.pause = 1'b0;
        push(4'd4, 6, 2'd0, 2'd0); push(4'd5, 1, 2'd0, 2'd0); push(4'd8, 2, 2'd0, 2'd0);
        push(4'd9, 1, 2'd0, 2'd0); push(4'd0, 2, 2'd0, 2'd0);
        consume();

        // Door opened during SPIN.
        phase = "door_spin";
        start_run(2'd0, 16'd2, 16'd8);
        push(4'd2, 1, 2'd0, 2'd0); push(4'd3, 1, 2'd0, 2'd0); push(4'd4, 2, 2'd0, 2'd0);
        push(4'd5, 1, 2'd0, 2'd0); push(4'd8, 3, 2'd0, 2'd0);
        consume();
        bus.door_closed = 1'b0;
        push(4'd11, 2, 2'd0, 2'd3);
        consume();
        apply_reset();

        // Zero durations and no rinses; door initially open holds CHECK_DOOR.
        phase = "zero_dur";
        start_run(2'd0, 16'd0, 16'd0);
        push(4'd1, 2, 2'd0, 2'd0);
        consume();
        bus.door_closed = 1'b1;
        push(4'd2, 1, 2'd0, 2'd0); push(4'd3, 1, 2'd0, 2'd0); push(4'd4, 1, 2'd0, 2'd0);
        push(4'd5, 1, 2'd0, 2'd0); push(4'd8, 1, 2'd0, 2'd0); push(4'd9, 1, 2'd0, 2'd0);
        push(4'd0, 2, 2'd0, 2'd0);
        consume();

        // Drain watchdog.
        phase = "drain_timeout";
        bus.drained = 1'b0;
        start_run(2'd0, 16'd0, 16'd0);
        push(4'd2, 1, 2'd0, 2'd0); push(4'd3, 1, 2'd0, 2'd0); push(4'd4, 1, 2'd0, 2'd0);
        push(4'd5, 200, 2'd0, 2'd0); push(4'd11, 3, 2'd0, 2'd2);
        consume();
        bus.drained = 1'b1;
        apply_reset();

        // Reset in the middle of the first rinse.
        phase = "reset_rinse";
        start_run(2'd2, 16'd10, 16'd8);
        push(4'd2, 1, 2'd2, 2'd0); push(4'd3, 1, 2'd2, 2'd0); push(4'd4, 10, 2'd2, 2'd0);
        push(4'd5, 1, 2'd2, 2'd0); push(4'd6, 1, 2'd1, 2'd0); push(4'd7, 2, 2'd1, 2'd0);
        consume();
        apply_reset();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/wash_cycle_controller.md
Name: wash_cycle_controller

Overview:
Parametrised successor to the single-pass washing machine FSM. It sequences fill, detergent, wash, a configurable number of rinses, drain and spin. Wash and spin durations come from internal timers rather than external time-out strobes. It adds pause/resume, fill and drain watchdogs, door-open detection and encoded error reporting. It sits between the front-panel logic and the valve, pump and motor drivers.

Parameters:
CNT_W, 16, width of duration inputs and internal timer
RINSE_W, 2, width of rinse_count (0..2^RINSE_W-1 rinses)
FILL_TIMEOUT, 200, max cycles in FILL or RINSE_FILL before fault
DRAIN_TIMEOUT, 200, max cycles in DRAIN before fault

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  level; sampled in IDLE only
pause  in  1  level; request pause while running
door_closed  in  1  door sensor, 1 = closed
water_full  in  1  level sensor, 1 = drum full
detergent_done  in  1  detergent dosing complete
drained  in  1  drum empty
rinse_count  in  RINSE_W  number of rinse passes, latched at start
wash_time  in  CNT_W  wash duration in cycles, latched at start
spin_time  in  CNT_W  spin duration in cycles, latched at start
state  out  4  current state encoding
door_lock, fill_valve, detergent_valve, motor_wash, drain_pump, motor_spin  out  1 each  actuator enables
rinse_left  out  RINSE_W  remaining rinse passes
done  out  1  one-cycle pulse on cycle completion
error_code  out  2  0 none, 1 fill timeout, 2 drain timeout, 3 door opened

Behaviour:
- Reset state: IDLE. All actuators 0. done=0, error_code=0, rinse_left=0, timer=0.
- State encoding: IDLE=0, CHECK_DOOR=1, FILL=2, DETERGENT=3, WASH=4, DRAIN=5, RINSE_FILL=6, RINSE=7, SPIN=8, DONE=9, PAUSED=10, ERROR=11.
- Outputs are Moore: decoded from the registered state and change the cycle after each transition.
- Run states are FILL..SPIN. door_lock=1 in run states and PAUSED; 0 elsewhere.
- Actuator decode:
  - fill_valve: FILL, RINSE_FILL
  - detergent_valve: DETERGENT
  - motor_wash: WASH, RINSE
  - drain_pump: DRAIN, SPIN
  - motor_spin: SPIN
- IDLE: on start=1, latch rinse_count, wash_time, spin_time into rinse_left and internal registers, then go to CHECK_DOOR. Inputs changing later have no effect until the next start.
- CHECK_DOOR: door_closed=1 -> FILL; otherwise wait indefinitely.
- Timer rule: cleared to 0 on entry to every state.
  - A timed state with limit N exits in the cycle where timer+1 >= max(N,1); otherwise timer increments.
  - So the state lasts max(N,1) cycles; N=0 gives 1 cycle.
- FILL: water_full -> DETERGENT. Otherwise FILL_TIMEOUT expiry -> ERROR, code 1. If both occur in the same cycle, water_full wins.
- DETERGENT: detergent_done -> WASH. No watchdog.
- WASH: timed, N = latched wash_time -> DRAIN.
- DRAIN: drained=1 and rinse_left>0 -> RINSE_FILL, with rinse_left decremented. drained=1 and rinse_left=0 -> SPIN. DRAIN_TIMEOUT expiry -> ERROR, code 2; drained wins if simultaneous.
- RINSE_FILL: same rules as FILL, but exits to RINSE.
- RINSE: timed, N = wash_time>>1 -> DRAIN.
- SPIN: timed, N = latched spin_time -> DONE.
- DONE: done=1 for exactly 1 cycle, then IDLE.
- Pause:
  - pause=1 in any run state -> PAUSED. The return state is saved and the timer is frozen, not cleared.
  - In PAUSED, all actuators are 0 except door_lock.
  - pause=0 -> return to the saved state with the timer resumed.
  - Watchdog counts also freeze while PAUSED.
- Door fault: door_closed=0 in any run state or PAUSED -> ERROR, code 3.
- Per-cycle priority: reset > door fault > pause > watchdog/normal transition.
- ERROR: all actuators 0, door_lock=0, error_code held. Only reset exits; start is ignored.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values, regardless of state.

Test Plan:
- Nominal run with rinse_count=2, wash_time=10, spin_time=8. Expected state sequence: 1,2,3,4(10 cycles),5,6,7(5 cycles),5,6,7,5,8(8 cycles),9,0. done pulses once; rinse_left steps 2->1->0.
- Hold water_full=0 in FILL with FILL_TIMEOUT=200 -> ERROR at entry+200 cycles, error_code=1, all actuators 0. start=1 leaves state=11; reset -> state=0.
- Assert pause for 20 cycles at WASH cycle 4 of 10 -> PAUSED with motor_wash=0 and door_lock=1. After release, WASH resumes for exactly 6 more cycles.
- Drop door_closed during SPIN -> next state ERROR, error_code=3, motor_spin=0, door_lock=0.
- wash_time=0, spin_time=0, rinse_count=0 -> WASH lasts 1 cycle and SPIN lasts 1 cycle; no RINSE states visited.
- Assert reset during RINSE with rinse_left=1 -> state=0, rinse_left=0, all outputs 0 on the next cycle. Change wash_time after start -> no effect on the current cycle.
